cal_alarm_clock: RTL and testbench

Next-generation timekeeping core for the lab digital clock. It keeps seconds, minutes and hours, plus day-of-week, date, month and a full year with a computed leap-year rule. It holds NA independent alarm channels; each channel has its own ring/snooze state machine and ring timeout. The block outputs binary fields only; the existing two-digit seven-segment drivers sit downstream of it.

---
 rtl/cal_alarm_clock.sv | 243 ++++++++++++++++++++++++
 tb/tb_cal_alarm_clock.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_alarm_clock.sv
// rtl/cal_alarm_clock.sv - calendar clock with NA independent ring/snooze alarm channels
// Optional feature macro: CAL_SNOOZE_EN builds the SNOOZED state, snooze counter and Snooze input.
module cal_alarm_clock #(
  parameter int NS      = 60,
  parameter int NH      = 24,
  parameter int ND      = 7,
  parameter int NA      = 2,
  parameter int YR0     = 2024,
  parameter int SNZ_MIN = 5,
  parameter int RING_S  = 60
) (
  input  logic          i_pulse,
  input  logic          i_reset,
  input  logic          i_timeset,
  input  logic          i_alarmset,
  input  logic          i_minadv,
  input  logic          i_hrsadv,
  input  logic          i_dayadv,
  input  logic          i_datadv,
  input  logic          i_monadv,
  input  logic          i_yradv,
  input  logic [1:0]    i_asel,
  input  logic [NA-1:0] i_alarmon,
  input  logic          i_snooze,
  input  logic          i_ack,
  output logic [6:0]    o_tsec,
  output logic [6:0]    o_tmin,
  output logic [6:0]    o_thrs,
  output logic [6:0]    o_tday,
  output logic [4:0]    o_tdate,
  output logic [3:0]    o_tmonth,
  output logic [11:0]   o_tyear,
  output logic [6:0]    o_dmin,
  output logic [6:0]    o_dhrs,
  output logic [6:0]    o_dday,
  output logic [NA-1:0] o_buzzch,
  output logic          o_buzz
);

`ifdef CAL_SNOOZE_EN
  localparam int CMAX = (RING_S > SNZ_MIN * NS) ? RING_S : SNZ_MIN * NS;
`else
  localparam int CMAX = RING_S;
`endif
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] RING_LD = CW'(RING_S - 1);

`ifdef CAL_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LD = CW'(SNZ_MIN * NS - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNZ} state_t;
`else
  typedef enum logic {ST_IDLE, ST_RING} state_t;
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze;
`endif

  logic [6:0]  r_sec, r_min, r_hrs, r_day;
  logic [4:0]  r_date;
  logic [3:0]  r_mon;
  logic [11:0] r_year;
  logic [6:0]  r_amin [NA];
  logic [6:0]  r_ahrs [NA];
  logic [6:0]  r_aday [NA];
  state_t      r_state [NA];
  logic [CW-1:0] r_cnt [NA];

  state_t        w_state_nxt [NA];
  logic [CW-1:0] w_cnt_nxt [NA];
  logic [NA-1:0] w_match;

  function automatic logic [4:0] f_maxd(input logic [3:0] mon, input logic [11:0] yr);
    logic leap;
    leap = (((yr % 12'd4) == 12'd0) && ((yr % 12'd100) != 12'd0)) || ((yr % 12'd400) == 12'd0);
    case (mon)
      4'd2:                     f_maxd = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  f_maxd = 5'd30;
      default:                  f_maxd = 5'd31;
    endcase
  endfunction

  logic        w_smax, w_mmax, w_hmax, w_dmax;
  logic [3:0]  w_mon_inc;
  logic [11:0] w_year_inc;
  logic [4:0]  w_maxd_cur, w_maxd_nmon, w_maxd_nyr;

  assign w_smax      = (r_sec == 7'(NS - 1));
  assign w_mmax      = (r_min == 7'(NS - 1));
  assign w_hmax      = (r_hrs == 7'(NH - 1));
  assign w_dmax      = (r_day == 7'(ND - 1));
  assign w_mon_inc   = (r_mon == 4'd12) ? 4'd1 : r_mon + 4'd1;
  assign w_year_inc  = r_year + 12'd1;
  assign w_maxd_cur  = f_maxd(r_mon, r_year);
  assign w_maxd_nmon = f_maxd(w_mon_inc, r_year);
  assign w_maxd_nyr  = f_maxd(r_mon, w_year_inc);

  always_ff @(posedge i_pulse) begin
    if (i_reset) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hrs  <= '0;
      r_day  <= '0;
      r_date <= 5'd1;
      r_mon  <= 4'd1;
      r_year <= 12'(YR0);
    end else if (i_timeset) begin
      if (i_minadv) r_min <= w_mmax ? '0 : r_min + 7'd1;
      if (i_hrsadv) r_hrs <= w_hmax ? '0 : r_hrs + 7'd1;
      if (i_dayadv) r_day <= w_dmax ? '0 : r_day + 7'd1;
      // One calendar action per cycle; month/year steps pull the date back into range.
      if (i_datadv) begin
        r_date <= (r_date >= w_maxd_cur) ? 5'd1 : r_date + 5'd1;
      end else if (i_monadv) begin
        r_mon <= w_mon_inc;
        if (r_date > w_maxd_nmon) r_date <= w_maxd_nmon;
      end else if (i_yradv) begin
        r_year <= w_year_inc;
        if (r_date > w_maxd_nyr) r_date <= w_maxd_nyr;
      end
    end else begin
      r_sec <= w_smax ? '0 : r_sec + 7'd1;
      if (w_smax) r_min <= w_mmax ? '0 : r_min + 7'd1;
      if (w_smax && w_mmax) r_hrs <= w_hmax ? '0 : r_hrs + 7'd1;
      if (w_smax && w_mmax && w_hmax) begin
        r_day <= w_dmax ? '0 : r_day + 7'd1;
        if (r_date == w_maxd_cur) begin
          r_date <= 5'd1;
          r_mon  <= w_mon_inc;
          if (r_mon == 4'd12) r_year <= w_year_inc;
        end else begin
          r_date <= r_date + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge i_pulse) begin
    if (i_reset) begin
      for (int i = 0; i < NA; i++) begin
        r_amin[i] <= '0;
        r_ahrs[i] <= '0;
        r_aday[i] <= '0;
      end
    end else if (i_alarmset && !i_timeset) begin
      for (int i = 0; i < NA; i++) begin
        if (int'(i_asel) == i) begin
          if (i_minadv) r_amin[i] <= (r_amin[i] == 7'(NS - 1)) ? '0 : r_amin[i] + 7'd1;
          if (i_hrsadv) r_ahrs[i] <= (r_ahrs[i] == 7'(NH - 1)) ? '0 : r_ahrs[i] + 7'd1;
          if (i_dayadv) r_aday[i] <= (r_aday[i] == 7'(ND - 1)) ? '0 : r_aday[i] + 7'd1;
        end
      end
    end
  end

  // Out-of-range Asel falls through to the time fields.
  always_comb begin
    o_dmin = r_min;
    o_dhrs = r_hrs;
    o_dday = r_day;
    if (i_alarmset && !i_timeset) begin
      for (int i = 0; i < NA; i++) begin
        if (int'(i_asel) == i) begin
          o_dmin = r_amin[i];
          o_dhrs = r_ahrs[i];
          o_dday = r_aday[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NA; i++) begin
      w_match[i]     = (r_min == r_amin[i]) && (r_hrs == r_ahrs[i]) && (r_day == r_aday[i]) &&
                       (r_sec == 7'd0) && !i_timeset;
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (!i_alarmon[i]) begin
        w_state_nxt[i] = ST_IDLE;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_match[i]) begin
              w_state_nxt[i] = ST_RING;
              w_cnt_nxt[i]   = RING_LD;
            end
          end
          ST_RING: begin
            if (i_ack) begin
              w_state_nxt[i] = ST_IDLE;
`ifdef CAL_SNOOZE_EN
            end else if (i_snooze) begin
              w_state_nxt[i] = ST_SNZ;
              w_cnt_nxt[i]   = SNZ_LD;
`endif
            end else if (r_cnt[i] == '0) begin
              w_state_nxt[i] = ST_IDLE;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            end
          end
`ifdef CAL_SNOOZE_EN
          ST_SNZ: begin
            if (i_ack) begin
              w_state_nxt[i] = ST_IDLE;
            end else if (r_cnt[i] == '0) begin
              w_state_nxt[i] = ST_RING;
              w_cnt_nxt[i]   = RING_LD;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            end
          end
`endif
          default: w_state_nxt[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_pulse) begin
    for (int i = 0; i < NA; i++) begin
      if (i_reset) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NA; i++) o_buzzch[i] = (r_state[i] == ST_RING);
  end

  assign o_buzz   = |o_buzzch;
  assign o_tsec   = r_sec;
  assign o_tmin   = r_min;
  assign o_thrs   = r_hrs;
  assign o_tday   = r_day;
  assign o_tdate  = r_date;
  assign o_tmonth = r_mon;
  assign o_tyear  = r_year;

endmodule

// File: tb/tb_cal_alarm_clock.sv
// tb/tb_cal_alarm_clock.sv - bench for cal_alarm_clock: calendar table, alarm sequences, random vs model
module tb_cal_alarm_clock;
  localparam int NA = 2;
  localparam int RING_S = 60;
  localparam int SNZ_MIN = 5;
`ifdef CAL_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  typedef struct packed {
    logic rst, ts, as, mina, hra, daya, data, mona, yra, snz, ack;
    logic [1:0] asel;
    logic [1:0] aon;
  } in_t;

  typedef struct {
    in_t in;
    int  n;
    int  h, m, s, date, mon, year;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur = '0;
  logic [6:0]  o_tsec, o_tmin, o_thrs, o_tday, o_dmin, o_dhrs, o_dday;
  logic [4:0]  o_tdate;
  logic [3:0]  o_tmonth;
  logic [11:0] o_tyear;
  logic [NA-1:0] o_buzzch;
  logic o_buzz;

  cal_alarm_clock dut (
    .i_pulse(clk), .i_reset(cur.rst), .i_timeset(cur.ts), .i_alarmset(cur.as),
    .i_minadv(cur.mina), .i_hrsadv(cur.hra), .i_dayadv(cur.daya), .i_datadv(cur.data),
    .i_monadv(cur.mona), .i_yradv(cur.yra), .i_asel(cur.asel), .i_alarmon(cur.aon),
    .i_snooze(cur.snz), .i_ack(cur.ack),
    .o_tsec(o_tsec), .o_tmin(o_tmin), .o_thrs(o_thrs), .o_tday(o_tday),
    .o_tdate(o_tdate), .o_tmonth(o_tmonth), .o_tyear(o_tyear),
    .o_dmin(o_dmin), .o_dhrs(o_dhrs), .o_dday(o_dday),
    .o_buzzch(o_buzzch), .o_buzz(o_buzz)
  );

  int vecs = 0;
  int miss = 0;

  // Reference model: time of day as a single seconds count, ring/snooze as remaining-cycle counts.
  int m_sod, m_dow, m_date, m_mon, m_year;
  int m_amin[NA], m_ahrs[NA], m_aday[NA], m_ring[NA], m_snz[NA];

  function automatic int dim(input int mon, input int yr);
    bit leap;
    leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    if (mon == 2) return leap ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  task automatic model_step(input in_t x);
    bit mt[NA];
    int h, mi, s, a;
    if (x.rst) begin
      m_sod = 0; m_dow = 0; m_date = 1; m_mon = 1; m_year = 2024;
      for (int i = 0; i < NA; i++) begin
        m_amin[i] = 0; m_ahrs[i] = 0; m_aday[i] = 0; m_ring[i] = 0; m_snz[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NA; i++)
      mt[i] = !x.ts && (m_sod % 60 == 0) && ((m_sod / 60) % 60 == m_amin[i]) &&
              (m_sod / 3600 == m_ahrs[i]) && (m_dow == m_aday[i]);
    for (int i = 0; i < NA; i++) begin
      if (!x.aon[i]) begin
        m_ring[i] = 0; m_snz[i] = 0;
      end else if (m_ring[i] > 0) begin
        if (x.ack) m_ring[i] = 0;
        else if (x.snz && SNZ) begin m_ring[i] = 0; m_snz[i] = SNZ_MIN * 60; end
        else m_ring[i]--;
      end else if (m_snz[i] > 0) begin
        if (x.ack) m_snz[i] = 0;
        else begin
          m_snz[i]--;
          if (m_snz[i] == 0) m_ring[i] = RING_S;
        end
      end else if (mt[i]) begin
        m_ring[i] = RING_S;
      end
    end
    if (x.as && !x.ts && x.asel < NA) begin
      a = int'(x.asel);
      if (x.mina) m_amin[a] = (m_amin[a] + 1) % 60;
      if (x.hra)  m_ahrs[a] = (m_ahrs[a] + 1) % 24;
      if (x.daya) m_aday[a] = (m_aday[a] + 1) % 7;
    end
    if (!x.ts) begin
      m_sod++;
      if (m_sod == 86400) begin
        m_sod = 0;
        m_dow = (m_dow + 1) % 7;
        if (m_date == dim(m_mon, m_year)) begin
          m_date = 1;
          if (m_mon == 12) begin m_mon = 1; m_year = (m_year + 1) % 4096; end
          else m_mon++;
        end else m_date++;
      end
    end else begin
      h = m_sod / 3600; mi = (m_sod / 60) % 60; s = m_sod % 60;
      if (x.mina) mi = (mi + 1) % 60;
      if (x.hra) h = (h + 1) % 24;
      if (x.daya) m_dow = (m_dow + 1) % 7;
      m_sod = h * 3600 + mi * 60 + s;
      if (x.data) m_date = m_date % dim(m_mon, m_year) + 1;
      else if (x.mona) begin
        m_mon = m_mon % 12 + 1;
        if (m_date > dim(m_mon, m_year)) m_date = dim(m_mon, m_year);
      end else if (x.yra) begin
        m_year = (m_year + 1) % 4096;
        if (m_date > dim(m_mon, m_year)) m_date = dim(m_mon, m_year);
      end
    end
  endtask

  task automatic mcheck();
    logic [72:0] a, e;
    logic [1:0] eb;
    int dm, dh, dd;
    dm = (m_sod / 60) % 60; dh = m_sod / 3600; dd = m_dow;
    if (cur.as && !cur.ts && cur.asel < NA) begin
      dm = m_amin[cur.asel]; dh = m_ahrs[cur.asel]; dd = m_aday[cur.asel];
    end
    for (int i = 0; i < NA; i++) eb[i] = (m_ring[i] > 0);
    a = {o_tsec, o_tmin, o_thrs, o_tday, o_tdate, o_tmonth, o_tyear, o_dmin, o_dhrs, o_dday, o_buzzch, o_buzz};
    e = {7'(m_sod % 60), 7'((m_sod / 60) % 60), 7'(m_sod / 3600), 7'(m_dow), 5'(m_date), 4'(m_mon),
         12'(m_year), 7'(dm), 7'(dh), 7'(dd), eb, |eb};
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL model t=%0t got=%h want=%h", $time, a, e);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input in_t x);
    cur = x;
    model_step(x);
    @(posedge clk);
    #1;
    mcheck();
  endtask

  task automatic run(input int n, input logic [1:0] aon);
    in_t x;
    x = '0; x.aon = aon;
    repeat (n) step(x);
  endtask

  task automatic goto_hm(input int h, input int m, input int d, input logic [1:0] aon);
    in_t x;
    for (int k = 0; k < 80; k++) begin
      if ((m_sod / 3600 == h) && ((m_sod / 60) % 60 == m) && (m_dow == d)) break;
      x = '0; x.ts = 1'b1; x.aon = aon;
      x.hra = (m_sod / 3600 != h);
      x.mina = ((m_sod / 60) % 60 != m);
      x.daya = (m_dow != d);
      step(x);
    end
  endtask

  task automatic to_sec(input int s, input logic [1:0] aon);
    for (int k = 0; k < 60; k++) begin
      if (m_sod % 60 == s) break;
      run(1, aon);
    end
  endtask

  task automatic ring_at_0730(input logic [1:0] aon);
    goto_hm(7, 29, 2, aon);
    to_sec(58, aon);
    run(3, aon);
  endtask

  vec_t tbl[$];

  task automatic add(input in_t in, input int n, input int h, input int m, input int s,
                     input int date, input int mon, input int year);
    tbl.push_back('{in, n, h, m, s, date, mon, year});
  endtask

  initial begin
    in_t x;
    vec_t v;

    add('{rst:1'b1, default:'0},                  1, 0, 0, 0, 1, 1, 2024);
    add('{ts:1'b1, hra:1'b1, mina:1'b1, default:'0}, 23, 23, 23, 0, 1, 1, 2024);
    add('{ts:1'b1, mina:1'b1, default:'0},        36, 23, 59, 0, 1, 1, 2024);
    add('{ts:1'b1, mona:1'b1, default:'0},        11, 23, 59, 0, 1, 12, 2024);
    add('{ts:1'b1, data:1'b1, default:'0},        30, 23, 59, 0, 31, 12, 2024);
    add('{default:'0},                            59, 23, 59, 59, 31, 12, 2024);
    add('{default:'0},                             1, 0, 0, 0, 1, 1, 2025);
    add('{ts:1'b1, data:1'b1, default:'0},        30, 0, 0, 0, 31, 1, 2025);
    add('{ts:1'b1, yra:1'b1, default:'0},          3, 0, 0, 0, 31, 1, 2028);
    add('{ts:1'b1, mona:1'b1, default:'0},         1, 0, 0, 0, 29, 2, 2028);
    add('{ts:1'b1, yra:1'b1, default:'0},          1, 0, 0, 0, 28, 2, 2029);
    add('{ts:1'b1, yra:1'b1, default:'0},         71, 0, 0, 0, 28, 2, 2100);
    add('{ts:1'b1, hra:1'b1, default:'0},         23, 23, 0, 0, 28, 2, 2100);
    add('{ts:1'b1, mina:1'b1, default:'0},        59, 23, 59, 0, 28, 2, 2100);
    add('{default:'0},                            59, 23, 59, 59, 28, 2, 2100);
    add('{default:'0},                             1, 0, 0, 0, 1, 3, 2100);
    add('{ts:1'b1, mona:1'b1, default:'0},        11, 0, 0, 0, 1, 2, 2100);
    add('{ts:1'b1, yra:1'b1, default:'0},        300, 0, 0, 0, 1, 2, 2400);
    add('{ts:1'b1, data:1'b1, default:'0},        28, 0, 0, 0, 29, 2, 2400);
    add('{ts:1'b1, data:1'b1, default:'0},         1, 0, 0, 0, 1, 2, 2400);
    add('{ts:1'b1, data:1'b1, default:'0},        27, 0, 0, 0, 28, 2, 2400);
    add('{ts:1'b1, hra:1'b1, default:'0},         23, 23, 0, 0, 28, 2, 2400);
    add('{ts:1'b1, mina:1'b1, default:'0},        59, 23, 59, 0, 28, 2, 2400);
    add('{default:'0},                            59, 23, 59, 59, 28, 2, 2400);
    add('{default:'0},                             1, 0, 0, 0, 29, 2, 2400);
    add('{ts:1'b1, data:1'b1, mona:1'b1, default:'0}, 1, 0, 0, 0, 1, 2, 2400);
    add('{ts:1'b1, mona:1'b1, yra:1'b1, default:'0},  1, 0, 0, 0, 1, 3, 2400);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      repeat (v.n) step(v.in);
      chk($sformatf("tbl%0d_hrs", r), o_thrs, v.h);
      chk($sformatf("tbl%0d_min", r), o_tmin, v.m);
      chk($sformatf("tbl%0d_sec", r), o_tsec, v.s);
      chk($sformatf("tbl%0d_date", r), o_tdate, v.date);
      chk($sformatf("tbl%0d_mon", r), o_tmonth, v.mon);
      chk($sformatf("tbl%0d_year", r), o_tyear, v.year);
      chk($sformatf("tbl%0d_buzz", r), o_buzz, 0);
    end

    // Timeset dominates Alarmset: time minute steps, seconds freeze, alarms untouched.
    x = '0; x.rst = 1'b1; step(x);
    run(5, 2'b00);
    x = '0; x.ts = 1'b1; x.as = 1'b1; x.mina = 1'b1; step(x);
    chk("tsas_tmin", o_tmin, 1);
    chk("tsas_tsec", o_tsec, 5);
    x = '0; x.as = 1'b1; step(x);
    chk("tsas_amin", o_dmin, 0);

    // Two channels: ch1 at 07:30 day 2, ch0 at 07:31 day 2.
    x = '0; x.rst = 1'b1; step(x);
    x = '0; x.as = 1'b1; x.asel = 2'd1;
    x.hra = 1'b1; repeat (7) step(x); x.hra = 1'b0;
    x.mina = 1'b1; repeat (30) step(x); x.mina = 1'b0;
    x.daya = 1'b1; repeat (2) step(x); x.daya = 1'b0;
    x.asel = 2'd0;
    x.hra = 1'b1; repeat (7) step(x); x.hra = 1'b0;
    x.mina = 1'b1; repeat (31) step(x); x.mina = 1'b0;
    x.daya = 1'b1; repeat (2) step(x); x.daya = 1'b0;
    x.asel = 2'd1; step(x);
    chk("disp_amin1", o_dmin, 30);
    chk("disp_ahrs1", o_dhrs, 7);
    chk("disp_aday1", o_dday, 2);
    goto_hm(7, 29, 2, 2'b00);
    to_sec(58, 2'b00);
    run(2, 2'b11);
    chk("pre_ring", o_buzzch, 2'b00);
    run(1, 2'b11);
    chk("ch1_ring", o_buzzch, 2'b10);
    chk("ch1_ring_sec", o_tsec, 1);
    chk("ch1_ring_buzz", o_buzz, 1);
    run(4, 2'b11);
    x = '0; x.aon = 2'b11; x.ack = 1'b1; step(x);
    chk("ack", o_buzzch, 2'b00);
    run(54, 2'b11);
    chk("pre_ch0", o_buzzch, 2'b00);
    run(1, 2'b11);
    chk("ch0_ring", o_buzzch, 2'b01);
    chk("ch0_ring_min", o_tmin, 31);
    run(59, 2'b11);
    chk("ring_last", o_buzzch, 2'b01);
    run(1, 2'b11);
    chk("ring_timeout", o_buzzch, 2'b00);

    // Snooze at 07:30:10; re-ring only in the snooze build.
    ring_at_0730(2'b10);
    chk("snz_ring", o_buzzch, 2'b10);
    run(9, 2'b10);
    x = '0; x.aon = 2'b10; x.snz = 1'b1; step(x);
    chk("snz_edge", o_buzzch, SNZ ? 2'b00 : 2'b10);
    run(299, 2'b10);
    chk("snz_quiet", o_buzzch, 2'b00);
    run(1, 2'b10);
    chk("snz_rering", o_buzzch, SNZ ? 2'b10 : 2'b00);
    run(59, 2'b10);
    chk("rering_last", o_buzzch, SNZ ? 2'b10 : 2'b00);
    run(1, 2'b10);
    chk("rering_end", o_buzzch, 2'b00);

    // Disarm while snoozed: no re-ring afterwards.
    ring_at_0730(2'b10);
    x = '0; x.aon = 2'b10; x.snz = 1'b1; step(x);
    run(1, 2'b00);
    run(310, 2'b10);
    chk("aon_off", o_buzzch, 2'b00);

    // Reset mid-ring.
    ring_at_0730(2'b10);
    chk("rst_pre", o_buzz, 1);
    x = '0; x.aon = 2'b10; x.rst = 1'b1; step(x);
    chk("rst_buzz", o_buzz, 0);
    chk("rst_hrs", o_thrs, 0);
    chk("rst_date", o_tdate, 1);

    // Randomized stimulus against the model.
    x = '0; x.rst = 1'b1; step(x);
    for (int k = 0; k < 3000; k++) begin
      x = '0;
      x.rst  = ($urandom_range(0, 299) == 0);
      x.ts   = ($urandom_range(0, 9) < 2);
      x.as   = ($urandom_range(0, 9) < 2);
      x.mina = ($urandom_range(0, 3) == 0);
      x.hra  = ($urandom_range(0, 3) == 0);
      x.daya = ($urandom_range(0, 3) == 0);
      x.data = ($urandom_range(0, 3) == 0);
      x.mona = ($urandom_range(0, 3) == 0);
      x.yra  = ($urandom_range(0, 3) == 0);
      x.asel = 2'($urandom_range(0, 3));
      x.aon  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      x.snz  = ($urandom_range(0, 14) == 0);
      x.ack  = ($urandom_range(0, 39) == 0);
      step(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
